// File: rtl/dynaq_uart_pkg.sv
// dynaq_uart_pkg: shared state encoding, line level and default bit period for the Dyna-Q UART transmitter
package dynaq_uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP} state_t;
endpackage

// File: rtl/dynaq_baud_tick.sv
// dynaq_baud_tick: bit-period counter (clk, reset, clear in; tick out on last cycle of each bit)
module dynaq_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= (clear || tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/dynaq_uart_tx.sv
// dynaq_uart_tx: 8-N-1 UART byte transmitter, LSB first (ports clk, reset, tx_dv, tx_byte -> tx_active, tx_serial, tx_done); UART_TX_PARITY_EN adds an even-parity bit
module dynaq_uart_tx
  import dynaq_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_dv,
  input  logic [7:0] tx_byte,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       tx_done
);
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic ser_q, ser_d, act_q, act_d, done_q, done_d, tick;
  dynaq_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(clk),
    .reset(reset),
    .clear(state_q == S_IDLE || state_q == S_CLEANUP),
    .tick(tick)
  );
  // outputs are registered from the next state so each level appears the cycle the state is entered
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    byte_d = byte_q;
    case (state_q)
      S_IDLE: if (tx_dv) begin
        state_d = S_START;
        byte_d = tx_byte;
        idx_d = '0;
      end
      S_START: if (tick) state_d = S_DATA;
      S_DATA: if (tick) begin
        idx_d = idx_q + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (idx_q == 3'd7) state_d = S_PARITY;
`else
        if (idx_q == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (tick) state_d = S_STOP;
`endif
      S_STOP: if (tick) state_d = S_CLEANUP;
      default: state_d = S_IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    ser_d = state_d == S_START ? ~UART_IDLE_LEVEL :
            state_d == S_DATA ? byte_d[idx_d] :
            state_d == S_PARITY ? ^byte_q : UART_IDLE_LEVEL;
`else
    ser_d = state_d == S_START ? ~UART_IDLE_LEVEL :
            state_d == S_DATA ? byte_d[idx_d] : UART_IDLE_LEVEL;
`endif
    act_d = state_d != S_IDLE && state_d != S_CLEANUP;
    done_d = state_d == S_CLEANUP;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      byte_q <= '0;
      ser_q <= UART_IDLE_LEVEL;
      act_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      byte_q <= byte_d;
      ser_q <= ser_d;
      act_q <= act_d;
      done_q <= done_d;
    end
  assign tx_serial = ser_q;
  assign tx_active = act_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_dynaq_uart_tx.sv
// tb_dynaq_uart_tx: directed self-checking bench for dynaq_uart_tx with CLKS_PER_BIT=4
module tb_dynaq_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int LVLS = 11;
`else
  localparam int LVLS = 10;
`endif
  logic clk = 1'b0, reset = 1'b1, tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic tx_active, tx_serial, tx_done;
  int npass = 0, ntotal = 0, cyc = 0, done_at = 0, d1 = 0;
  dynaq_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .tx_dv(tx_dv),
    .tx_byte(tx_byte),
    .tx_active(tx_active),
    .tx_serial(tx_serial),
    .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input int obs, input int exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_ser"}, int'(tx_serial), 1);
    chk({tag, "_act"}, int'(tx_active), 0);
    chk({tag, "_done"}, int'(tx_done), 0);
  endtask
  // send byte b; optionally pulse 8'hFF at cycle inj, or assert reset at cycle rst_c
  task automatic run_frame(input logic [7:0] b, input int inj, input int rst_c);
    int lvl, last;
    logic e;
    last = CPB * LVLS + 1;
    tx_dv = 1'b1;
    tx_byte = b;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      lvl = (c - 1) / CPB;
      e = (c == last) ? 1'b1 : (lvl == 0) ? 1'b0 : (lvl <= 8) ? b[lvl-1] :
          (lvl == 9 && LVLS == 11) ? ^b : 1'b1;
      chk($sformatf("ser_%02h_c%0d", b, c), int'(tx_serial), int'(e));
      chk($sformatf("act_%02h_c%0d", b, c), int'(tx_active), int'(c < last));
      chk($sformatf("done_%02h_c%0d", b, c), int'(tx_done), int'(c == last));
      if (c == last) done_at = cyc;
      tx_dv = (c == inj);
      tx_byte = (c == inj) ? 8'hFF : b;
      if (c == rst_c) begin
        reset = 1'b1;
        #1;
        idle_chk("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
          @(negedge clk);
          idle_chk("post_rst");
        end
        return;
      end
    end
    @(negedge clk);
    idle_chk($sformatf("after_%02h", b));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    idle_chk("in_rst");
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      idle_chk("idle");
    end
    run_frame(8'h35, 0, 0);
    repeat (3) @(negedge clk);
    run_frame(8'h00, 10, 0);
    repeat (4) begin
      @(negedge clk);
      idle_chk("no_ff");
    end
    run_frame(8'hA5, 0, 15);
    run_frame(8'h41, 0, 0);
    repeat (2) @(negedge clk);
    run_frame(8'h30, 0, 0);
    d1 = done_at;
    run_frame(8'h31, 0, 0);
    chk("b2b_spacing", done_at - d1, CPB * LVLS + 2);
`ifdef UART_TX_PARITY_EN
    repeat (2) @(negedge clk);
    run_frame(8'h07, 0, 0);
`endif
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
